vend_session_ctrl: RTL

Session controller for the coin-operated vending machine. It conditions the three raw active-low keys, turns them into single arbitrated events, and tracks credit against a fixed price. It sequences the dispense, change-payout and beep phases, and refunds credit on cancel or inactivity. It sits between the board keys and the dispense/payout/buzzer drivers, and is the single owner of machine credit.

---
 rtl/vend_session_ctrl_if.sv | 12 +
 rtl/vend_session_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_session_ctrl_if.sv
// Key and status bundle between the board keys, the vending session controller and its drivers.
interface vend_session_ctrl_if;
    logic [2:0] key_value;
    logic [3:0] credit;
    logic       dispense;
    logic       change_pulse;
    logic       beep;
    logic       busy;

    modport master (output key_value, input credit, dispense, change_pulse, beep, busy);
    modport slave  (input key_value, output credit, dispense, change_pulse, beep, busy);
endinterface

// File: rtl/vend_session_ctrl.sv
// Vending session controller: key conditioning, credit tracking, vend/payout/beep sequencing.
// Optional idle auto-refund is built only when VEND_TIMEOUT_EN is defined.
module vend_session_ctrl #(
    parameter int DEB_CNT     = 16,
    parameter int PRICE       = 5,
    parameter int CHG_GAP     = 4,
    parameter int BEEP_CYCLES = 8,
    parameter int TIMEOUT     = 4000
) (
    input  logic                clk,
    input  logic                rst_n,
    vend_session_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE, S_REFUND, S_DONE} state_t;

    localparam int DEB_W  = $clog2(DEB_CNT + 1);
    localparam int GAP_W  = $clog2(CHG_GAP + 1);
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    if (PRICE < 1 || PRICE > 13 || CHG_GAP < 2 || BEEP_CYCLES < 1 || TIMEOUT < 1 || DEB_CNT < 1) begin : g_bad_params
        $error("vend_session_ctrl: illegal parameter value");
    end

    logic [2:0] ev;

    // Per key: two-flop synchronizer, then a debounced level that flips after DEB_CNT stable cycles.
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        logic             sync1_q, sync1_d, sync2_q, sync2_d;
        logic             level_q, level_d, ev_q, ev_d;
        logic [DEB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = bus.key_value[gi];
            sync2_d = sync1_q;
            level_d = level_q;
            ev_d    = 1'b0;
            cnt_d   = '0;
            if (sync2_q != level_q) begin
                if (cnt_q == DEB_W'(DEB_CNT - 1)) begin
                    level_d = sync2_q;
                    ev_d    = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                level_q <= 1'b1;
                ev_q    <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                level_q <= level_d;
                ev_q    <= ev_d;
                cnt_q   <= cnt_d;
            end
        end

        assign ev[gi] = ev_q;
    end

    state_t            state_q, state_d;
    logic [3:0]        credit_q, credit_d;
    logic              dispense_q, dispense_d;
    logic              pulse_q, pulse_d;
    logic              beep_q, beep_d;
    logic              busy_q, busy_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    logic [2:0] ev_ok;
    logic       cancel_ev, coin_ev, timeout_hit;
    logic [3:0] coin_val, credit_sum;

    // Cancel beats 1.0 beats 0.5; anything arriving while busy is dropped.
    assign ev_ok      = busy_q ? 3'b000 : ev;
    assign cancel_ev  = ev_ok[0];
    assign coin_ev    = ~ev_ok[0] & (ev_ok[1] | ev_ok[2]);
    assign coin_val   = ev_ok[2] ? 4'd2 : 4'd1;
    assign credit_sum = credit_q + coin_val;

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             phase_q, phase_d;

    // Timer advances on every second COLLECT cycle; a coin (or leaving COLLECT) clears it.
    always_comb begin
        timer_d     = '0;
        phase_d     = 1'b0;
        timeout_hit = 1'b0;
        if (state_q == S_COLLECT && !coin_ev) begin
            phase_d     = ~phase_q;
            timer_d     = phase_q ? timer_q + TMR_W'(1) : timer_q;
            timeout_hit = phase_q && (timer_q == TMR_W'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            phase_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        pulse_d    = 1'b0;
        beep_d     = 1'b0;
        gap_d      = gap_q;
        beep_cnt_d = beep_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (coin_ev) begin
                    credit_d = credit_sum;
                    state_d  = (credit_sum >= 4'(PRICE)) ? S_VEND : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel_ev) begin
                    if (credit_q != 4'd0) begin
                        state_d = S_REFUND;
                        pulse_d = 1'b1;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (coin_ev) begin
                    credit_d = credit_sum;
                    if (credit_sum >= 4'(PRICE)) state_d = S_VEND;
                end else if (timeout_hit) begin
                    state_d = S_REFUND;
                    pulse_d = 1'b1;
                    gap_d   = '0;
                end
            end
            S_VEND: begin
                credit_d = credit_q - 4'(PRICE);
                if (credit_q != 4'(PRICE)) begin
                    state_d = S_CHANGE;
                    pulse_d = 1'b1;
                    gap_d   = '0;
                end else begin
                    state_d    = S_DONE;
                    beep_d     = 1'b1;
                    beep_cnt_d = '0;
                end
            end
            S_CHANGE, S_REFUND: begin
                // A pulse cycle pays one half-unit; otherwise count towards the next pulse.
                if (pulse_q) begin
                    credit_d = credit_q - 4'd1;
                    gap_d    = GAP_W'(1);
                    if (credit_q == 4'd1) begin
                        state_d    = S_DONE;
                        beep_d     = 1'b1;
                        beep_cnt_d = '0;
                    end
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                    pulse_d = (gap_q + GAP_W'(1)) == GAP_W'(CHG_GAP);
                end
            end
            S_DONE: begin
                if (beep_cnt_q == BEEP_W'(BEEP_CYCLES - 1)) begin
                    state_d    = S_IDLE;
                    beep_cnt_d = '0;
                end else begin
                    beep_d     = 1'b1;
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        dispense_d = (state_d == S_VEND);
        busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE) ||
                     (state_d == S_REFUND) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            credit_q   <= 4'd0;
            dispense_q <= 1'b0;
            pulse_q    <= 1'b0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            gap_q      <= '0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            pulse_q    <= pulse_d;
            beep_q     <= beep_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.dispense     = dispense_q;
    assign bus.change_pulse = pulse_q;
    assign bus.beep         = beep_q;
    assign bus.busy         = busy_q;
endmodule
